// File: rtl/acondicionador_botones.sv
// Button front-end: synchronize, debounce and classify raw push-button pins
// into clean levels plus one-cycle press, release and long-hold events.
module acondicionador_botones #(
    parameter int N_BOT      = 4,
    parameter int TICK_DIV   = 50000,
    parameter int DEB_TICKS  = 20,
    parameter int HOLD_TICKS = 5000
) (
    input  logic             clk,
    input  logic             Bot_Reset,
    input  logic [N_BOT-1:0] btn_raw,
    output logic [N_BOT-1:0] btn_level,
    output logic [N_BOT-1:0] btn_pulse,
    output logic [N_BOT-1:0] btn_release,
    output logic [N_BOT-1:0] btn_hold,
    output logic             modo_test
);

    localparam int DIV_W  = $clog2(TICK_DIV - 1) + 1;
    localparam int DEB_W  = $clog2(DEB_TICKS) + 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } state_t;

    logic [DIV_W-1:0]  div_q, div_d;
    logic              tick;
    logic [N_BOT-1:0]  s1_q, s1_d;
    logic [N_BOT-1:0]  s2_q, s2_d;
    logic [N_BOT-1:0]  level_q, level_d;
    logic [N_BOT-1:0]  pulse_q, pulse_d;
    logic [N_BOT-1:0]  rel_q, rel_d;
    logic [N_BOT-1:0]  hold_q, hold_d;
    logic              modo_q, modo_d;
    logic [DEB_W-1:0]  deb_q [N_BOT];
    logic [DEB_W-1:0]  deb_d [N_BOT];
    logic [HOLD_W-1:0] hcnt_q [N_BOT];
    logic [HOLD_W-1:0] hcnt_d [N_BOT];
    state_t            st_q [N_BOT];
    state_t            st_d [N_BOT];

    assign tick = (div_q == DIV_W'(TICK_DIV - 1));

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        s1_d    = btn_raw;
        s2_d    = s1_q;
        level_d = level_q;
        pulse_d = '0;
        rel_d   = '0;
        hold_d  = '0;
        for (int i = 0; i < N_BOT; i++) begin
            deb_d[i]  = deb_q[i];
            hcnt_d[i] = hcnt_q[i];
            st_d[i]   = st_q[i];
            // a single agreeing tick restarts the debounce window
            if (tick) begin
                if (s2_q[i] != level_q[i]) begin
                    if (deb_q[i] == DEB_W'(DEB_TICKS - 1)) begin
                        level_d[i] = s2_q[i];
                        deb_d[i]   = '0;
                    end else begin
                        deb_d[i] = deb_q[i] + 1'b1;
                    end
                end else begin
                    deb_d[i] = '0;
                end
            end
            unique case (st_q[i])
                IDLE: begin
                    if (level_q[i]) begin
                        st_d[i]    = PRESSED;
                        pulse_d[i] = 1'b1;
                        hcnt_d[i]  = '0;
                    end
                end
                PRESSED: begin
                    if (!level_q[i]) begin
                        st_d[i]  = IDLE;
                        rel_d[i] = 1'b1;
                    end else if (tick) begin
                        if (hcnt_q[i] == HOLD_W'(HOLD_TICKS - 1)) begin
                            hcnt_d[i] = HOLD_W'(HOLD_TICKS);
                            hold_d[i] = 1'b1;
                            st_d[i]   = HELD;
                        end else begin
                            hcnt_d[i] = hcnt_q[i] + 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!level_q[i]) begin
                        st_d[i]  = IDLE;
                        rel_d[i] = 1'b1;
                    end
                end
                default: st_d[i] = IDLE;
            endcase
        end
        modo_d = modo_q ^ hold_d[0];
    end

    always_ff @(posedge clk or negedge Bot_Reset) begin
        if (!Bot_Reset) begin
            div_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            pulse_q <= '0;
            rel_q   <= '0;
            hold_q  <= '0;
            modo_q  <= 1'b0;
            for (int i = 0; i < N_BOT; i++) begin
                deb_q[i]  <= '0;
                hcnt_q[i] <= '0;
                st_q[i]   <= IDLE;
            end
        end else begin
            div_q   <= div_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            rel_q   <= rel_d;
            hold_q  <= hold_d;
            modo_q  <= modo_d;
            for (int i = 0; i < N_BOT; i++) begin
                deb_q[i]  <= deb_d[i];
                hcnt_q[i] <= hcnt_d[i];
                st_q[i]   <= st_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_pulse   = pulse_q;
    assign btn_release = rel_q;
    assign btn_hold    = hold_q;
    assign modo_test   = modo_q;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Bench for acondicionador_botones: cycle model compared every clock,
// plus directed scenarios with hand-computed windows and counts.
module tb_acondicionador_botones;

    localparam int NB = 4;
    localparam int TD = 4;
    localparam int DT = 3;
    localparam int HT = 10;

    logic          clk = 1'b0;
    logic          Bot_Reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level, btn_pulse, btn_release, btn_hold;
    logic          modo_test;

    int n_chk  = 0;
    int n_fail = 0;

    acondicionador_botones #(
        .N_BOT(NB), .TICK_DIV(TD), .DEB_TICKS(DT), .HOLD_TICKS(HT)
    ) dut (
        .clk(clk),
        .Bot_Reset(Bot_Reset),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .btn_release(btn_release),
        .btn_hold(btn_hold),
        .modo_test(modo_test)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // ---------------- behavioural model ----------------
    int ecnt = 0;
    bit m_r1 [NB], m_r2 [NB], m_lvl [NB], m_old [NB], m_fired [NB];
    int m_dc [NB], m_htk [NB];
    logic [NB-1:0] e_lvl = '0, e_pul = '0, e_rel = '0, e_hld = '0;
    logic e_mode = 1'b0;

    always @(posedge clk or negedge Bot_Reset) begin
        if (!Bot_Reset) begin
            ecnt = 0;
            for (int i = 0; i < NB; i++) begin
                m_r1[i] = 0; m_r2[i] = 0; m_lvl[i] = 0; m_old[i] = 0;
                m_fired[i] = 0; m_dc[i] = 0; m_htk[i] = 0;
            end
            e_lvl = '0; e_pul = '0; e_rel = '0; e_hld = '0; e_mode = 1'b0;
        end else begin
            bit tk, s, cur, old;
            ecnt = ecnt + 1;
            tk = (ecnt % TD == 0);
            for (int i = 0; i < NB; i++) begin
                s = m_r2[i];
                m_r2[i] = m_r1[i];
                m_r1[i] = btn_raw[i];
                cur = m_lvl[i];
                old = m_old[i];
                e_pul[i] = cur && !old;
                e_rel[i] = !cur && old;
                e_hld[i] = 1'b0;
                if (!old) begin
                    m_htk[i] = 0;
                    m_fired[i] = 0;
                end else if (cur && tk && !m_fired[i]) begin
                    m_htk[i]++;
                    if (m_htk[i] == HT) begin
                        e_hld[i] = 1'b1;
                        m_fired[i] = 1;
                    end
                end
                m_old[i] = cur;
                if (tk) begin
                    if (s != cur) begin
                        m_dc[i]++;
                        if (m_dc[i] == DT) begin
                            m_lvl[i] = s;
                            m_dc[i] = 0;
                        end
                    end else begin
                        m_dc[i] = 0;
                    end
                end
                e_lvl[i] = m_lvl[i];
            end
            e_mode = e_mode ^ e_hld[0];
        end
    end

    always @(negedge clk) begin
        chk("model_level", int'(btn_level), int'(e_lvl));
        chk("model_pulse", int'(btn_pulse), int'(e_pul));
        chk("model_release", int'(btn_release), int'(e_rel));
        chk("model_hold", int'(btn_hold), int'(e_hld));
        chk("model_modo", int'(modo_test), int'(e_mode));
    end

    // ---------------- event monitor ----------------
    int cyc = 0;
    int p_cnt [NB], r_cnt [NB], h_cnt [NB], lp_cyc [NB], lh_cyc [NB];
    int n_allp = 0;
    initial for (int i = 0; i < NB; i++) begin
        p_cnt[i] = 0; r_cnt[i] = 0; h_cnt[i] = 0; lp_cyc[i] = 0; lh_cyc[i] = 0;
    end

    always @(negedge clk) begin
        cyc++;
        if (Bot_Reset === 1'b1) begin
            for (int i = 0; i < NB; i++) begin
                if (btn_pulse[i]) begin p_cnt[i]++; lp_cyc[i] = cyc; end
                if (btn_release[i]) r_cnt[i]++;
                if (btn_hold[i]) begin h_cnt[i]++; lh_cyc[i] = cyc; end
            end
            if (btn_pulse == 4'hF) n_allp++;
        end
    end

    // ---------------- directed stimulus ----------------
    int sp [NB], sr [NB], sh [NB];
    int sallp;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < NB; i++) begin
            sp[i] = p_cnt[i]; sr[i] = r_cnt[i]; sh[i] = h_cnt[i];
        end
        sallp = n_allp;
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, int'({btn_level, btn_pulse, btn_release, btn_hold, modo_test}), 0);
    endtask

    task automatic wait_lvl(input int b, input bit v, input int lim, output int n);
        n = 0;
        while (btn_level[b] !== v && n < lim) begin
            step(1);
            n++;
        end
        if (btn_level[b] !== v) chk("wait_level_timeout", int'(btn_level[b]), int'(v));
    endtask

    initial begin
        int n;
        Bot_Reset = 1'b0;
        btn_raw   = 4'hF;
        repeat (5) begin
            step(1);
            chk_zero("in_reset");
        end
        Bot_Reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk_zero("after_reset");
            if (k == 7) btn_raw = '0;
        end
        step(20);
        chk("two_tick_glitch_level", int'(btn_level), 0);

        snap();
        btn_raw[1] = 1'b1;
        wait_lvl(1, 1'b1, 30, n);
        chk_rng("debounce_latency", n, 11, 14);
        step(10);
        btn_raw[1] = 1'b0;
        wait_lvl(1, 1'b0, 30, n);
        step(5);
        chk("short_pulse1", p_cnt[1] - sp[1], 1);
        chk("short_release1", r_cnt[1] - sr[1], 1);
        chk("short_nohold1", h_cnt[1] - sh[1], 0);

        n = 0;
        while (ecnt % TD != 3 && n < 8) begin step(1); n++; end
        snap();
        for (int j = 0; j < 30; j++) begin
            btn_raw[2] = (j % 2 == 0);
            step(2);
        end
        step(30);
        chk("bounce_level2", int'(btn_level[2]), 0);
        chk("bounce_pulse2", p_cnt[2] - sp[2], 0);
        chk("bounce_release2", r_cnt[2] - sr[2], 0);

        snap();
        btn_raw[1] = 1'b1;
        step(80);
        chk("long_hold1_count", h_cnt[1] - sh[1], 1);
        chk_rng("hold_distance", lh_cyc[1] - lp_cyc[1], 37, 40);
        chk("modo_after_hold1", int'(modo_test), 0);
        btn_raw[1] = 1'b0;
        step(25);

        snap();
        btn_raw[0] = 1'b1;
        step(80);
        chk("modo_first_hold", int'(modo_test), 1);
        btn_raw[0] = 1'b0;
        step(25);
        snap();
        btn_raw[0] = 1'b1;
        step(20);
        btn_raw[0] = 1'b0;
        step(25);
        chk("modo_short_press", int'(modo_test), 1);
        chk("short0_pulse", p_cnt[0] - sp[0], 1);
        chk("short0_release", r_cnt[0] - sr[0], 1);
        chk("short0_nohold", h_cnt[0] - sh[0], 0);
        btn_raw[0] = 1'b1;
        step(80);
        chk("modo_second_hold", int'(modo_test), 0);
        btn_raw[0] = 1'b0;
        step(25);

        snap();
        btn_raw = 4'hF;
        step(20);
        chk("all_pulse_joint", n_allp - sallp, 1);
        chk("all_level", int'(btn_level), 'hF);
        Bot_Reset = 1'b0;
        #1;
        chk_zero("async_reset_clear");
        step(3);
        Bot_Reset = 1'b1;
        snap();
        step(25);
        chk("repress_pulse_joint", n_allp - sallp, 1);
        chk("repress_level", int'(btn_level), 'hF);
        for (int i = 0; i < NB; i++) chk("no_release_after_reset", r_cnt[i] - sr[i], 0);
        btn_raw = '0;
        step(25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
